// File: rtl/seq_datapath.sv
// Self-sequencing register-file datapath: fetches operands, runs the shifter/ALU,
// writes back and pulses done, one register-to-register instruction per start.
module seq_datapath #(
  parameter int W    = 16,
  parameter int NREG = 8,
  localparam int RW  = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [RW-1:0] rd,
  input  logic [RW-1:0] rn,
  input  logic [RW-1:0] rm,
  input  logic [1:0]    shift,
  input  logic [W-1:0]  imm,
  input  logic [W-1:0]  ext_in,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  c_out,
  output logic          z,
  output logic          n,
  output logic          v
);

  typedef enum logic [2:0] {
    OP_MOVI = 3'b000,
    OP_MOV  = 3'b001,
    OP_ADD  = 3'b010,
    OP_CMP  = 3'b011,
    OP_AND  = 3'b100,
    OP_MVN  = 3'b101,
    OP_LDX  = 3'b110,
    OP_NOP  = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RDA  = 3'd1,
    S_RDB  = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4,
    S_DONE = 3'd5
  } state_e;

  // Two's-complement overflow: operands share a sign that the result does not.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  state_e          state_r, state_next_s;
  op_e             op_r;
  logic [RW-1:0]   rd_r, rn_r, rm_r;
  logic [1:0]      shift_r;
  logic [W-1:0]    imm_r, ext_r;
  logic [W-1:0]    a_r, b_r, c_r;
  logic            z_r, n_r, v_r;
  logic            busy_r, done_r;
  logic [W-1:0]    regs_r [NREG];

  logic            accept_s;
  logic            wr_en_s;
  logic            upd_flags_s;
  logic [W-1:0]    sh_b_s;
  logic [W-1:0]    alu_res_s;
  logic            alu_v_s;
  logic [W-1:0]    c_next_s;

  assign accept_s = (state_r == S_IDLE) && start;

  // Next-state decode; direct loads skip operand fetch, NOP goes straight to DONE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if (op == OP_NOP) begin
            state_next_s = S_DONE;
          end else if ((op == OP_MOVI) || (op == OP_LDX)) begin
            state_next_s = S_EXEC;
          end else begin
            state_next_s = S_RDA;
          end
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_RDA:   state_next_s = S_RDB;
      S_RDB:   state_next_s = S_EXEC;
      S_EXEC:  state_next_s = S_WB;
      S_WB:    state_next_s = S_DONE;
      S_DONE:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // State register with busy/done registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != S_IDLE);
      done_r  <= (state_next_s == S_DONE);
    end
  end

  // Instruction holding registers, captured only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r    <= OP_NOP;
      rd_r    <= {RW{1'b0}};
      rn_r    <= {RW{1'b0}};
      rm_r    <= {RW{1'b0}};
      shift_r <= 2'b00;
      imm_r   <= {W{1'b0}};
      ext_r   <= {W{1'b0}};
    end else if (accept_s) begin
      op_r    <= op_e'(op);
      rd_r    <= rd;
      rn_r    <= rn;
      rm_r    <= rm;
      shift_r <= shift;
      imm_r   <= imm;
      ext_r   <= ext_in;
    end
  end

  // Shifter on the B operand.
  always_comb begin
    sh_b_s = b_r;
    case (shift_r)
      2'b00:   sh_b_s = b_r;
      2'b01:   sh_b_s = {b_r[W-2:0], 1'b0};
      2'b10:   sh_b_s = {1'b0, b_r[W-1:1]};
      2'b11:   sh_b_s = {b_r[W-1], b_r[W-1:1]};
      default: sh_b_s = b_r;
    endcase
  end

  // ALU and flag-update qualification.
  always_comb begin
    alu_res_s   = {W{1'b0}};
    alu_v_s     = 1'b0;
    upd_flags_s = 1'b0;
    case (op_r)
      OP_MOV: alu_res_s = sh_b_s;
      OP_ADD: begin
        alu_res_s   = a_r + sh_b_s;
        alu_v_s     = add_ovf(a_r[W-1], sh_b_s[W-1], alu_res_s[W-1]);
        upd_flags_s = 1'b1;
      end
      OP_CMP: begin
        alu_res_s   = a_r - sh_b_s;
        alu_v_s     = add_ovf(a_r[W-1], ~sh_b_s[W-1], alu_res_s[W-1]);
        upd_flags_s = 1'b1;
      end
      OP_AND: begin
        alu_res_s   = a_r & sh_b_s;
        upd_flags_s = 1'b1;
      end
      OP_MVN: begin
        alu_res_s   = ~sh_b_s;
        upd_flags_s = 1'b1;
      end
      default: begin
        alu_res_s   = {W{1'b0}};
        alu_v_s     = 1'b0;
        upd_flags_s = 1'b0;
      end
    endcase
  end

  // C source select: direct loads bypass the ALU.
  always_comb begin
    c_next_s = alu_res_s;
    if (op_r == OP_MOVI) begin
      c_next_s = imm_r;
    end else if (op_r == OP_LDX) begin
      c_next_s = ext_r;
    end else begin
      c_next_s = alu_res_s;
    end
  end

  assign wr_en_s = (state_r == S_WB) && (op_r != OP_CMP);

  // Operand, result and flag registers, each loaded in its own FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= {W{1'b0}};
      b_r <= {W{1'b0}};
      c_r <= {W{1'b0}};
      z_r <= 1'b0;
      n_r <= 1'b0;
      v_r <= 1'b0;
    end else begin
      if (state_r == S_RDA) begin
        a_r <= regs_r[rn_r];
      end
      if (state_r == S_RDB) begin
        b_r <= regs_r[rm_r];
      end
      if (state_r == S_EXEC) begin
        c_r <= c_next_s;
        if (upd_flags_s) begin
          z_r <= (alu_res_s == {W{1'b0}});
          n_r <= alu_res_s[W-1];
          v_r <= alu_v_s;
        end
      end
    end
  end

  // Register file; write-back happens after both reads, so rd may alias rn/rm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {W{1'b0}};
      end
    end else if (wr_en_s) begin
      regs_r[rd_r] <= c_r;
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign c_out = c_r;
  assign z     = z_r;
  assign n     = n_r;
  assign v     = v_r;

endmodule
